router_pkt_tx: RTL and testbench

Packet transmitter that drives the router's input port. Upstream logic loads up to 63 payload bytes into an internal buffer and then issues a send command with a destination address. The block then emits the router byte stream: a header byte, the payload bytes with `pkt_valid` high, and a trailing parity byte with `pkt_valid` low. It obeys the router's `busy` back-pressure. It is the source end of the router's `pkt_valid`/`data_in`/`busy` input interface.

---
 rtl/router_pkt_tx.sv | 166 ++++++++++++++++
 tb/tb_router_pkt_tx.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// Packet source for the router input port. Payload bytes are buffered while
// idle; a send command then streams header, payload (pkt_valid high) and a
// trailing parity byte (pkt_valid low), honouring the router's busy hold.
module router_pkt_tx (
    input  logic       clock,
    input  logic       resetn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       send,
    input  logic [1:0] addr,
    input  logic       corrupt,
    input  logic       busy,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       buf_full,
    output logic       tx_busy,
    output logic       cmd_err,
    output logic       done
);

    localparam int unsigned DEPTH = 63;

    typedef enum logic [1:0] {IDLE, HDR, PAY, PAR} state_t;

    state_t     state_q, state_d;
    logic [5:0] wr_ptr_q, wr_ptr_d;
    logic [5:0] rd_ptr_q, rd_ptr_d;
    logic [5:0] len_q, len_d;
    logic [7:0] par_acc_q, par_acc_d;
    logic [7:0] data_out_q, data_out_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic       corrupt_q, corrupt_d;
    logic       cmd_err_q, cmd_err_d;
    logic       done_q, done_d;

    logic [7:0] buf_mem [0:DEPTH-1];
    logic       buf_we;
    logic [7:0] rd_byte;
    logic [7:0] hdr;
    logic       full;
    logic       send_ok;
    logic       consume;
    logic       more;

    assign full    = (wr_ptr_q == 6'd63);
    assign send_ok = send && (addr != 2'd3) && (wr_ptr_q != 6'd0);
    // The router takes the byte currently on data_out at any edge without busy.
    assign consume = (state_q != IDLE) && !busy;
    assign more    = (rd_ptr_q < len_q);
    assign rd_byte = buf_mem[rd_ptr_q];
    assign hdr     = {wr_ptr_q, addr};

    assign pkt_valid = pkt_valid_q;
    assign data_out  = data_out_q;
    assign buf_full  = full;
    assign tx_busy   = (state_q != IDLE);
    assign cmd_err   = cmd_err_q;
    assign done      = done_q;

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: advance only when the current byte is consumed.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (send_ok) state_d = HDR;
            HDR, PAY: if (consume) state_d = more ? PAY : PAR;
            PAR:      if (consume) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Datapath / output next values: buffer loading, byte sequencing, parity.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        len_d       = len_q;
        par_acc_d   = par_acc_q;
        data_out_d  = data_out_q;
        pkt_valid_d = pkt_valid_q;
        corrupt_d   = corrupt_q;
        cmd_err_d   = 1'b0;
        done_d      = 1'b0;
        buf_we      = 1'b0;
        case (state_q)
            IDLE: begin
                if (send) begin
                    // A write in the same cycle as any send is dropped.
                    if (send_ok) begin
                        len_d       = wr_ptr_q;
                        corrupt_d   = corrupt;
                        data_out_d  = hdr;
                        pkt_valid_d = 1'b1;
                        par_acc_d   = hdr;
                        rd_ptr_d    = 6'd0;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end else if (wr_en && !full) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 6'd1;
                end
            end
            HDR, PAY: begin
                if (consume) begin
                    if (more) begin
                        data_out_d = rd_byte;
                        par_acc_d  = par_acc_q ^ rd_byte;
                        rd_ptr_d   = rd_ptr_q + 6'd1;
                    end else begin
                        data_out_d  = corrupt_q ? ~par_acc_q : par_acc_q;
                        pkt_valid_d = 1'b0;
                    end
                end
            end
            PAR: begin
                if (consume) begin
                    data_out_d = 8'h00;
                    done_d     = 1'b1;
                    wr_ptr_d   = 6'd0;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset aborts any packet and empties the buffer.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            wr_ptr_q    <= 6'd0;
            rd_ptr_q    <= 6'd0;
            len_q       <= 6'd0;
            par_acc_q   <= 8'h00;
            data_out_q  <= 8'h00;
            pkt_valid_q <= 1'b0;
            corrupt_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            len_q       <= len_d;
            par_acc_q   <= par_acc_d;
            data_out_q  <= data_out_d;
            pkt_valid_q <= pkt_valid_d;
            corrupt_q   <= corrupt_d;
            cmd_err_q   <= cmd_err_d;
            done_q      <= done_d;
        end
    end

    // Payload buffer write port (contents need no reset).
    always_ff @(posedge clock) begin
        if (resetn && buf_we) begin
            buf_mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: expected router bytes are queued
// when a packet is sent and compared as the router consumes each byte.
module tb_router_pkt_tx;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       send = 1'b0;
    logic [1:0] addr = 2'd0;
    logic       corrupt = 1'b0;
    logic       busy = 1'b0;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       buf_full;
    logic       tx_busy;
    logic       cmd_err;
    logic       done;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q [$];     // {pkt_valid, data_out} per consumed byte
    logic [7:0] model_buf [$]; // bytes the bench believes are loaded
    logic       mon_en = 1'b0;
    logic       done_exp = 1'b0;

    router_pkt_tx dut (
        .clock     (clock),
        .resetn    (resetn),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .send      (send),
        .addr      (addr),
        .corrupt   (corrupt),
        .busy      (busy),
        .pkt_valid (pkt_valid),
        .data_out  (data_out),
        .buf_full  (buf_full),
        .tx_busy   (tx_busy),
        .cmd_err   (cmd_err),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
        if (model_buf.size() < 63) model_buf.push_back(b);
    endtask

    // Legal send: queue header, payload and parity, then pulse send.
    task automatic send_pkt(input logic [1:0] a, input logic corr);
        logic [7:0] h;
        logic [7:0] p;
        h = {model_buf.size()[5:0], a};
        p = h;
        exp_q.push_back({1'b1, h});
        foreach (model_buf[i]) begin
            exp_q.push_back({1'b1, model_buf[i]});
            p = p ^ model_buf[i];
        end
        exp_q.push_back({1'b0, corr ? ~p : p});
        model_buf.delete();
        addr    = a;
        corrupt = corr;
        send    = 1'b1;
        tick();
        send    = 1'b0;
        corrupt = 1'b0;
        check_eq("tx_busy_after_send", tx_busy, 1);
        check_eq("cmd_err_legal", cmd_err, 0);
    endtask

    // Illegal send: expect a single cmd_err pulse and no packet.
    task automatic send_bad(input logic [1:0] a);
        addr = a;
        send = 1'b1;
        tick();
        send = 1'b0;
        check_eq("cmd_err_pulse", cmd_err, 1);
        check_eq("pkt_valid_bad", pkt_valid, 0);
        check_eq("tx_busy_bad", tx_busy, 0);
        tick();
        check_eq("cmd_err_clear", cmd_err, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((tx_busy || exp_q.size() != 0) && n < 300) begin
            tick();
            n++;
        end
        if (tx_busy || exp_q.size() != 0) check_eq("timeout_idle", 32'd0, 32'd1);
    endtask

    // Monitor: compare each byte as the router consumes it, and the done pulse.
    always @(negedge clock) begin
        logic [8:0] e;
        logic       nxt;
        if (mon_en) begin
            nxt = 1'b0;
            check_eq("done", done, done_exp);
            if (tx_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_byte", {23'd0, pkt_valid, data_out}, 32'h1ff);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("byte", {23'd0, pkt_valid, data_out}, {23'd0, e});
                    nxt = !e[8];
                end
            end
            done_exp = nxt;
        end
    end

    initial begin
        repeat (3) tick();
        check_eq("rst_pkt_valid", pkt_valid, 0);
        check_eq("rst_data_out", data_out, 0);
        check_eq("rst_tx_busy", tx_busy, 0);
        check_eq("rst_buf_full", buf_full, 0);
        check_eq("rst_cmd_err", cmd_err, 0);
        check_eq("rst_done", done, 0);
        resetn = 1'b1;
        mon_en = 1'b1;
        tick();

        // Basic 3-byte packet to port 1.
        load(8'h11); load(8'h22); load(8'h33);
        send_pkt(2'd1, 1'b0);
        check_eq("hdr_0D", data_out, 8'h0D);
        wait_idle();
        tick();

        // Same packet with busy on 0x22 and on the parity byte.
        load(8'h11); load(8'h22); load(8'h33);
        send_pkt(2'd1, 1'b0);
        tick();
        tick();
        check_eq("pay_22", data_out, 8'h22);
        busy = 1'b1;
        tick();
        check_eq("hold_22_a", data_out, 8'h22);
        tick();
        check_eq("hold_22_b", data_out, 8'h22);
        busy = 1'b0;
        tick();
        check_eq("pay_33", data_out, 8'h33);
        tick();
        check_eq("par_0D", data_out, 8'h0D);
        busy = 1'b1;
        tick();
        check_eq("par_hold", data_out, 8'h0D);
        check_eq("par_hold_busy", tx_busy, 1);
        busy = 1'b0;
        wait_idle();
        tick();

        // Illegal address, then legal send of the same 2 bytes; empty send.
        load(8'hA5); load(8'h3C);
        send_bad(2'd3);
        send_pkt(2'd0, 1'b0);
        wait_idle();
        tick();
        send_bad(2'd2);

        // Fill the buffer: 64 writes, last one ignored.
        for (int i = 0; i < 64; i++) begin
            load(8'(i));
            if (i == 61) check_eq("not_full_62", buf_full, 0);
            if (i == 62) check_eq("full_63", buf_full, 1);
        end
        check_eq("full_64", buf_full, 1);
        send_pkt(2'd2, 1'b0);
        check_eq("hdr_FE", data_out, 8'hFE);
        wait_idle();
        tick();
        check_eq("empty_after_full", buf_full, 0);

        // Corrupted parity; writes and sends during transmission are ignored.
        load(8'h11); load(8'h22); load(8'h33);
        send_pkt(2'd1, 1'b1);
        wr_en   = 1'b1;
        wr_data = 8'h99;
        send    = 1'b1;
        addr    = 2'd3;
        tick();
        wr_en = 1'b0;
        send  = 1'b0;
        check_eq("no_cmd_err_busy", cmd_err, 0);
        wait_idle();
        tick();
        send_bad(2'd0);

        // Reset while a payload byte is on data_out.
        load(8'h44); load(8'h55); load(8'h66);
        send_pkt(2'd2, 1'b0);
        tick();
        check_eq("pay_44", data_out, 8'h44);
        mon_en = 1'b0;
        resetn = 1'b0;
        tick();
        exp_q.delete();
        model_buf.delete();
        done_exp = 1'b0;
        check_eq("rst_mid_pkt_valid", pkt_valid, 0);
        check_eq("rst_mid_data_out", data_out, 0);
        check_eq("rst_mid_tx_busy", tx_busy, 0);
        resetn = 1'b1;
        tick();
        mon_en = 1'b1;
        check_eq("rst_mid_buf_full", buf_full, 0);
        load(8'h01); load(8'h80);
        send_pkt(2'd1, 1'b0);
        wait_idle();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
